// File: rtl/async_line_fifo_pkg.sv
// Shared helpers for async_line_fifo: log2 sizing, binary/gray conversion and
// pointer width derivation.
package async_line_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Pointers carry one extra MSB so that full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/async_line_fifo_gray_sync.sv
// Two-flop synchroniser for a gray-coded pointer; asynchronous active-low
// reset to zero. One instance per crossing direction.
module gray_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_gray
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_gray;
      r_sync <= r_meta;
    end
  end

  assign o_gray = r_sync;

endmodule

// File: rtl/async_line_fifo.sv
// Dual-clock first-word-fall-through line FIFO with gray pointer crossing.
// Optional per-word even parity when ASYNC_LINE_FIFO_PARITY_EN is defined.
module async_line_fifo
  import async_line_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32768,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  localparam int AW       = clog2(DEPTH),
  localparam int PW       = ptr_w(DEPTH)
) (
  input  logic              rd_clk,
  input  logic              w_rdrst_n,
  input  logic              wr_clk,
  input  logic              w_wrrst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic [PW-1:0]     wr_count,
  output logic [DATA_W-1:0] dout,
  input  logic              rd_en,
  output logic              empty,
  output logic              almost_empty,
  output logic              underflow,
  output logic [PW-1:0]     rd_count,
  output logic              parity_err
);

`ifdef ASYNC_LINE_FIFO_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif

  logic [MW-1:0] r_mem [DEPTH];
  logic [MW-1:0] w_wr_word;
  logic [MW-1:0] w_rd_word;

`ifdef ASYNC_LINE_FIFO_PARITY_EN
  assign w_wr_word = {^din, din};
`else
  assign w_wr_word = din;
`endif

  // ---------------- write domain ----------------
  logic [PW-1:0] r_wbin, r_wgray, r_wr_count;
  logic [PW-1:0] w_wbin_next, w_wgray_next, w_rgray_sync, w_rbin_sync, w_wr_count_next;
  logic          r_full, r_almost_full, r_overflow;
  logic          w_wr_ok;

  assign w_wr_ok         = wr_en & ~r_full;
  assign w_wbin_next     = r_wbin + PW'(w_wr_ok);
  assign w_wgray_next    = PW'(bin2gray(32'(w_wbin_next)));
  assign w_rbin_sync     = PW'(gray2bin(32'(w_rgray_sync)));
  assign w_wr_count_next = w_wbin_next - w_rbin_sync;

  always_ff @(posedge wr_clk or negedge w_wrrst_n) begin
    if (!w_wrrst_n) begin
      r_wbin        <= '0;
      r_wgray       <= '0;
      r_wr_count    <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_wbin        <= w_wbin_next;
      r_wgray       <= w_wgray_next;
      r_wr_count    <= w_wr_count_next;
      // Full when the write pointer laps the read pointer: top two gray bits inverted.
      r_full        <= (w_wgray_next == {~w_rgray_sync[PW-1:PW-2], w_rgray_sync[PW-3:0]});
      r_almost_full <= (w_wr_count_next >= PW'(AFULL_TH));
      if (wr_en && r_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (w_wr_ok) r_mem[r_wbin[AW-1:0]] <= w_wr_word;
  end

  // ---------------- read domain ----------------
  logic [PW-1:0] r_rbin, r_rgray, r_rd_count;
  logic [PW-1:0] w_rbin_next, w_rgray_next, w_wgray_sync, w_wbin_sync, w_rd_count_next;
  logic          r_empty, r_almost_empty, r_underflow;
  logic          w_rd_ok;

  assign w_rd_ok         = rd_en & ~r_empty;
  assign w_rbin_next     = r_rbin + PW'(w_rd_ok);
  assign w_rgray_next    = PW'(bin2gray(32'(w_rbin_next)));
  assign w_wbin_sync     = PW'(gray2bin(32'(w_wgray_sync)));
  assign w_rd_count_next = w_wbin_sync - w_rbin_next;

  always_ff @(posedge rd_clk or negedge w_rdrst_n) begin
    if (!w_rdrst_n) begin
      r_rbin         <= '0;
      r_rgray        <= '0;
      r_rd_count     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_rbin         <= w_rbin_next;
      r_rgray        <= w_rgray_next;
      r_rd_count     <= w_rd_count_next;
      r_empty        <= (w_rgray_next == w_wgray_sync);
      r_almost_empty <= (w_rd_count_next <= PW'(AEMPTY_TH));
      if (rd_en && r_empty) r_underflow <= 1'b1;
    end
  end

  assign w_rd_word = r_mem[r_rbin[AW-1:0]];

`ifdef ASYNC_LINE_FIFO_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge rd_clk or negedge w_rdrst_n) begin
    if (!w_rdrst_n) begin
      r_parity_err <= 1'b0;
    end else if (w_rd_ok && (^w_rd_word)) begin
      r_parity_err <= 1'b1;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // ---------------- pointer crossings ----------------
  gray_sync #(.W(PW)) u_rptr_sync (
    .i_clk   (wr_clk),
    .i_rst_n (w_wrrst_n),
    .i_gray  (r_rgray),
    .o_gray  (w_rgray_sync)
  );

  gray_sync #(.W(PW)) u_wptr_sync (
    .i_clk   (rd_clk),
    .i_rst_n (w_rdrst_n),
    .i_gray  (r_wgray),
    .o_gray  (w_wgray_sync)
  );

  assign full         = r_full;
  assign almost_full  = r_almost_full;
  assign overflow     = r_overflow;
  assign wr_count     = r_wr_count;
  assign dout         = w_rd_word[DATA_W-1:0];
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign underflow    = r_underflow;
  assign rd_count     = r_rd_count;

endmodule

// File: tb/tb_async_line_fifo.sv
// Bench for async_line_fifo (DATA_W=8, DEPTH=16, AFULL_TH=12, AEMPTY_TH=3),
// checked against a queue model of FIFO contents.
`timescale 1ns/1ps
module tb_async_line_fifo;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = 12;
  localparam int AEMPTY_TH = 3;
  localparam int PW        = 5;
  localparam int N_STREAM  = 10000;

  logic              rd_clk = 1'b0;
  logic              wr_clk = 1'b0;
  logic              w_rdrst_n = 1'b0;
  logic              w_wrrst_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic              full, almost_full, overflow, empty, almost_empty, underflow, parity_err;
  logic [PW-1:0]     wr_count, rd_count;
  logic [DATA_W-1:0] dout;

  realtime wr_half = 5.0;
  realtime rd_half = 13.5;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] model_q[$];

  always #(wr_half) wr_clk = ~wr_clk;
  always #(rd_half) rd_clk = ~rd_clk;

  async_line_fifo #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .rd_clk       (rd_clk),
    .w_rdrst_n    (w_rdrst_n),
    .wr_clk       (wr_clk),
    .w_wrrst_n    (w_wrrst_n),
    .din          (din),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .wr_count     (wr_count),
    .dout         (dout),
    .rd_en        (rd_en),
    .empty        (empty),
    .almost_empty (almost_empty),
    .underflow    (underflow),
    .rd_count     (rd_count),
    .parity_err   (parity_err)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Both resets assert together; each releases on its own clock.
  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    w_wrrst_n = 1'b0;
    w_rdrst_n = 1'b0;
    repeat (3) @(posedge rd_clk);
    @(negedge wr_clk) w_wrrst_n = 1'b1;
    @(negedge rd_clk) w_rdrst_n = 1'b1;
    model_q.delete();
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d);
    @(negedge wr_clk);
    din = d;
    wr_en = 1'b1;
    @(posedge wr_clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Returns at a rd_clk negedge with empty low, or reports a timeout.
  task automatic wait_not_empty(input string tag);
    bit seen;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge rd_clk);
      if (!empty) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: empty=%0b after 20 rd cycles, required 0", tag, empty);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        for (int i = 0; i < 5; i++) write_word(8'($urandom));
        repeat (6) @(posedge rd_clk);
        do_reset();
      end
      repeat (6) @(posedge rd_clk);
      #1;
      n_cmp++;
      if ({empty, almost_empty, full, almost_full, overflow, underflow, parity_err} !== 7'b1100000) begin
        n_bad++;
        $display("FAIL reset_flags pass%0d: e/ae/f/af/ov/un/pe=%b required 1100000", pass,
                 {empty, almost_empty, full, almost_full, overflow, underflow, parity_err});
      end
      n_cmp++;
      if (wr_count !== '0 || rd_count !== '0) begin
        n_bad++;
        $display("FAIL reset_counts pass%0d: wr_count=%0d rd_count=%0d required 0/0", pass, wr_count, rd_count);
      end
    end
  endtask

  task automatic test_fill_overflow();
    bit cleared;
    wr_half = 5.0;
    rd_half = 13.5;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge wr_clk);
      din = 8'(i);
      wr_en = 1'b1;
      @(posedge wr_clk);
      #1;
      n_cmp++;
      if (full !== (i == DEPTH - 1) || wr_count !== PW'(i + 1)) begin
        n_bad++;
        $display("FAIL fill_write%0d: full=%0b wr_count=%0d required full=%0b wr_count=%0d",
                 i, full, wr_count, (i == DEPTH - 1), i + 1);
      end
    end
    @(negedge wr_clk);
    din = 8'hAA;
    wr_en = 1'b1;
    @(posedge wr_clk);
    #1;
    n_cmp++;
    if (overflow !== 1'b1 || full !== 1'b1 || wr_count !== PW'(DEPTH)) begin
      n_bad++;
      $display("FAIL overflow_write: overflow=%0b full=%0b wr_count=%0d required 1/1/%0d",
               overflow, full, wr_count, DEPTH);
    end
    @(negedge wr_clk) wr_en = 1'b0;

    wait_not_empty("fill_visible");
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (dout !== 8'(i)) begin
        n_bad++;
        $display("FAIL fill_read%0d: dout=%02h required %02h", i, dout, 8'(i));
      end
      rd_en = 1'b1;
      @(posedge rd_clk);
      #1;
      n_cmp++;
      if (empty !== (i == DEPTH - 1)) begin
        n_bad++;
        $display("FAIL fill_pop%0d: empty=%0b required %0b", i, empty, (i == DEPTH - 1));
      end
      @(negedge rd_clk);
      rd_en = 1'b0;
    end

    cleared = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge wr_clk);
      if (!full && wr_count == '0) begin
        cleared = 1;
        break;
      end
    end
    n_cmp++;
    if (!cleared) begin
      n_bad++;
      $display("FAIL full_release: full=%0b wr_count=%0d required 0/0", full, wr_count);
    end
  endtask

  task automatic test_underflow();
    @(negedge rd_clk);
    rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en = 1'b0;
    n_cmp++;
    if (underflow !== 1'b1 || empty !== 1'b1 || rd_count !== '0) begin
      n_bad++;
      $display("FAIL underflow_set: underflow=%0b empty=%0b rd_count=%0d required 1/1/0", underflow, empty, rd_count);
    end
    write_word(8'h5A);
    wait_not_empty("underflow_visible");
    n_cmp++;
    if (dout !== 8'h5A || underflow !== 1'b1) begin
      n_bad++;
      $display("FAIL underflow_sticky: dout=%02h underflow=%0b required 5a/1", dout, underflow);
    end
    rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    n_cmp++;
    if (empty !== 1'b1) begin
      n_bad++;
      $display("FAIL underflow_pop: empty=%0b required 1", empty);
    end
    @(negedge rd_clk) rd_en = 1'b0;
    do_reset();
    repeat (2) @(posedge rd_clk);
    #1;
    n_cmp++;
    if (underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL underflow_clear: underflow=%0b required 0", underflow);
    end
  endtask

  task automatic test_almost();
    bit seen;
    int remain;
    do_reset();
    for (int k = 1; k <= AFULL_TH; k++) begin
      logic [DATA_W-1:0] d;
      d = 8'($urandom);
      model_q.push_back(d);
      write_word(d);
      n_cmp++;
      if (almost_full !== (k >= AFULL_TH)) begin
        n_bad++;
        $display("FAIL almost_full_at%0d: almost_full=%0b required %0b", k, almost_full, (k >= AFULL_TH));
      end
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge rd_clk);
      if (rd_count == PW'(AFULL_TH)) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (!seen || almost_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL almost_rd_count: rd_count=%0d almost_empty=%0b required %0d/0", rd_count, almost_empty, AFULL_TH);
    end
    for (int k = 1; k <= AFULL_TH; k++) begin
      n_cmp++;
      if (dout !== model_q[0]) begin
        n_bad++;
        $display("FAIL almost_data%0d: dout=%02h required %02h", k, dout, model_q[0]);
      end
      void'(model_q.pop_front());
      remain = AFULL_TH - k;
      rd_en = 1'b1;
      @(posedge rd_clk);
      #1;
      n_cmp++;
      if (rd_count !== PW'(remain) || almost_empty !== (remain <= AEMPTY_TH)) begin
        n_bad++;
        $display("FAIL almost_empty_at%0d: rd_count=%0d almost_empty=%0b required %0d/%0b",
                 remain, rd_count, almost_empty, remain, (remain <= AEMPTY_TH));
      end
      @(negedge rd_clk);
      rd_en = 1'b0;
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge wr_clk);
      if (wr_count == '0) begin
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (!seen || almost_full !== 1'b0) begin
      n_bad++;
      $display("FAIL almost_full_release: wr_count=%0d almost_full=%0b required 0/0", wr_count, almost_full);
    end
  endtask

  task automatic test_stream();
    int sent;
    int got;
    wr_half = 10.0;
    rd_half = 10.0;
    do_reset();
    sent = 0;
    got = 0;
    fork
      begin
        for (int c = 0; c < 40000 && sent < N_STREAM; c++) begin
          @(negedge wr_clk);
          wr_en = ($urandom_range(0, 3) != 0) && !full;
          if (wr_en) begin
            din = 8'($urandom);
            model_q.push_back(din);
            sent++;
          end
        end
        @(negedge wr_clk) wr_en = 1'b0;
      end
      begin
        for (int c = 0; c < 40000 && got < N_STREAM; c++) begin
          @(negedge rd_clk);
          rd_en = 1'b0;
          if (!empty) begin
            n_cmp++;
            if (model_q.size() == 0) begin
              n_bad++;
              $display("FAIL stream_phantom: empty=0 with no word written");
            end else begin
              if (dout !== model_q[0] || rd_count > PW'(model_q.size())) begin
                n_bad++;
                $display("FAIL stream_word%0d: dout=%02h rd_count=%0d required %02h rd_count<=%0d",
                         got, dout, rd_count, model_q[0], model_q.size());
              end
              if ($urandom_range(0, 3) != 0) begin
                rd_en = 1'b1;
                void'(model_q.pop_front());
                got++;
              end
            end
          end
        end
        @(posedge rd_clk);
        #1;
        rd_en = 1'b0;
      end
    join
    n_cmp++;
    if (got != N_STREAM || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_totals: received=%0d overflow=%0b underflow=%0b required %0d/0/0",
               got, overflow, underflow, N_STREAM);
    end
  endtask

  task automatic test_parity();
`ifdef ASYNC_LINE_FIFO_PARITY_EN
    do_reset();
    write_word(8'h3C);
    wait_not_empty("parity_visible");
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_clean: parity_err=%0b required 0", parity_err);
    end
    dut.r_mem[0][0] = ~dut.r_mem[0][0];
    rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    rd_en = 1'b0;
    @(posedge rd_clk);
    #1;
    n_cmp++;
    if (parity_err !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_flip: parity_err=%0b required 1", parity_err);
    end
`else
    n_cmp++;
    if (parity_err !== 1'b0) begin
      n_bad++;
      $display("FAIL parity_off: parity_err=%0b required 0", parity_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_underflow();
    test_almost();
    test_stream();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
